// File: rtl/i2c_slave_regfile_pkg.sv
// Shared I2C slave constants: FSM encodings and
// register-file defaults.
package i2c_slave_regfile_pkg;

  localparam int         ADDR_W_DEF    = 4;
  localparam logic [7:0] RESET_VAL_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/i2c_slave_regfile_edge_rise.sv
// Rising-edge detector; the previous sample resets to 1.
// Ports: clk, reset (async low), d_i level, rise_o pulse.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // Reset to 1 so a level already high at release
  // is not seen as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave register file: pointer/data write FSM,
// auto-increment reads, local host write port.
// Ports: clk, reset (async low); I2C side txn_start,
// rx_data/rx_valid, tx_req, tx_data; host side
// host_addr/wdata/we, host_rdata; wr_strobe/wr_addr
// report I2C writes; host_collision flags drops.
module i2c_slave_regfile
  import i2c_slave_regfile_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0] RESET_VAL = RESET_VAL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              txn_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_we,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              host_collision
);

  localparam int NREG = 2 ** ADDR_W;

  logic start_e;
  logic rx_e;
  logic tx_e;

  edge_rise u_start (
    .clk   (clk),
    .reset (reset),
    .d_i   (txn_start),
    .rise_o(start_e)
  );

  edge_rise u_rx (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx_valid),
    .rise_o(rx_e)
  );

  edge_rise u_tx (
    .clk   (clk),
    .reset (reset),
    .d_i   (tx_req),
    .rise_o(tx_e)
  );

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              i2c_we;
  logic              coll;

  logic [7:0]        regs_q [NREG];
  logic [7:0]        tx_data_q;
  logic [7:0]        host_rdata_q;
  logic              wr_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              host_coll_q;

  // START wins over rx/tx; rx wins over tx so a
  // simultaneous pair bumps the pointer only once.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    i2c_we  = 1'b0;
    priority case (1'b1)
      start_e: state_d = PTR;
      rx_e: begin
        unique case (state_q)
          PTR: begin
            ptr_d   = rx_data[ADDR_W-1:0];
            state_d = DATA;
          end
          DATA: begin
            i2c_we = 1'b1;
            ptr_d  = ptr_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
      tx_e: begin
        if (state_q != IDLE)
          ptr_d = ptr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign coll = host_we & i2c_we
              & (host_addr == ptr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i2c_we && ptr_q == ADDR_W'(i))
          regs_q[i] <= rx_data;
        else if (host_we && host_addr == ADDR_W'(i))
          regs_q[i] <= host_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_q    <= RESET_VAL;
      host_rdata_q <= RESET_VAL;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      host_coll_q  <= 1'b0;
    end else begin
      tx_data_q    <= regs_q[ptr_q];
      host_rdata_q <= regs_q[host_addr];
      wr_strobe_q  <= i2c_we;
      host_coll_q  <= coll;
      if (i2c_we)
        wr_addr_q <= ptr_q;
    end
  end

  assign tx_data        = tx_data_q;
  assign host_rdata     = host_rdata_q;
  assign wr_strobe      = wr_strobe_q;
  assign wr_addr        = wr_addr_q;
  assign host_collision = host_coll_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: writes,
// combined read, wrap, collision, reset cases.
module tb_i2c_slave_regfile;
  import i2c_slave_regfile_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       txn_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_we;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic       host_collision;

  int checks = 0;
  int errors = 0;

  i2c_slave_regfile dut (
    .clk           (clk),
    .reset         (reset),
    .txn_start     (txn_start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_req        (tx_req),
    .tx_data       (tx_data),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_we       (host_we),
    .host_rdata    (host_rdata),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .host_collision(host_collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    txn_start = 1'b1;
    tick();
    txn_start = 1'b0;
    tick();
  endtask

  task automatic tx_pulse();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    tick();
  endtask

  // Send one byte; check the strobe right after the
  // detecting edge and that it drops a cycle later.
  task automatic rx_byte(input logic [7:0] b,
                         input logic       s_exp,
                         input logic [3:0] a_exp);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    chk("wr_strobe", 32'(wr_strobe), 32'(s_exp));
    if (s_exp)
      chk("wr_addr", 32'(wr_addr), 32'(a_exp));
    rx_valid = 1'b0;
    tick();
    if (s_exp)
      chk("wr_strobe_off", 32'(wr_strobe), 32'(0));
  endtask

  task automatic rd_reg(input logic [3:0] idx,
                        input logic [7:0] exp);
    host_addr = idx;
    tick();
    chk($sformatf("reg%0d", idx),
        32'(host_rdata), 32'(exp));
  endtask

  task automatic host_wr(input logic [3:0] idx,
                         input logic [7:0] d);
    host_addr  = idx;
    host_wdata = d;
    host_we    = 1'b1;
    tick();
    host_we    = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    txn_start  = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    tx_req     = 1'b0;
    host_addr  = 4'h0;
    host_wdata = 8'h00;
    host_we    = 1'b0;
    tick();
    tick();
    chk("rst_tx", 32'(tx_data), 32'h00);
    chk("rst_hrd", 32'(host_rdata), 32'h00);
    chk("rst_strb", 32'(wr_strobe), 32'(0));
    chk("rst_coll", 32'(host_collision), 32'(0));
    chk("rst_st", 32'(dut.state_q), 32'(IDLE));
    chk("rst_ptr", 32'(dut.ptr_q), 32'(0));
    reset = 1'b1;
    tick();

    // plain I2C write
    start_pulse();
    chk("st_ptr", 32'(dut.state_q), 32'(PTR));
    rx_byte(8'h03, 1'b0, 4'h0);
    chk("st_data", 32'(dut.state_q), 32'(DATA));
    rx_byte(8'hA5, 1'b1, 4'h3);
    rx_byte(8'h5A, 1'b1, 4'h4);
    chk("ptr5", 32'(dut.ptr_q), 32'(5));
    rd_reg(4'h3, 8'hA5);
    rd_reg(4'h4, 8'h5A);

    // combined read after repeated START
    host_wr(4'h7, 8'h11);
    host_wr(4'h8, 8'h22);
    chk("hw_noptr", 32'(dut.ptr_q), 32'(5));
    start_pulse();
    rx_byte(8'h07, 1'b0, 4'h0);
    start_pulse();
    chk("rd_ptr7", 32'(dut.ptr_q), 32'(7));
    chk("tx_11", 32'(tx_data), 32'h11);
    tx_pulse();
    chk("tx_22", 32'(tx_data), 32'h22);
    tx_pulse();
    chk("ptr9", 32'(dut.ptr_q), 32'(9));
    chk("tx_st", 32'(dut.state_q), 32'(PTR));

    // pointer wrap
    start_pulse();
    rx_byte(8'hFF, 1'b0, 4'h0);
    chk("ptr15", 32'(dut.ptr_q), 32'(15));
    rx_byte(8'hC1, 1'b1, 4'hF);
    rx_byte(8'hC2, 1'b1, 4'h0);
    chk("ptr_wrap", 32'(dut.ptr_q), 32'(1));
    rd_reg(4'hF, 8'hC1);
    rd_reg(4'h0, 8'hC2);

    // host/I2C collision on reg2
    start_pulse();
    rx_byte(8'h02, 1'b0, 4'h0);
    rx_data    = 8'h44;
    rx_valid   = 1'b1;
    host_addr  = 4'h2;
    host_wdata = 8'h99;
    host_we    = 1'b1;
    tick();
    host_we  = 1'b0;
    rx_valid = 1'b0;
    chk("coll_on", 32'(host_collision), 32'(1));
    chk("coll_strb", 32'(wr_strobe), 32'(1));
    chk("coll_addr", 32'(wr_addr), 32'(2));
    tick();
    chk("coll_off", 32'(host_collision), 32'(0));
    rd_reg(4'h2, 8'h44);
    chk("coll_ptr", 32'(dut.ptr_q), 32'(3));

    // reset mid-transaction
    start_pulse();
    rx_byte(8'h06, 1'b0, 4'h0);
    reset = 1'b0;
    #1;
    chk("mr_st", 32'(dut.state_q), 32'(IDLE));
    chk("mr_ptr", 32'(dut.ptr_q), 32'(0));
    chk("mr_tx", 32'(tx_data), 32'h00);
    tick();
    reset = 1'b1;
    tick();
    rx_byte(8'hEE, 1'b0, 4'h0);
    chk("mr_ptr2", 32'(dut.ptr_q), 32'(0));
    chk("mr_st2", 32'(dut.state_q), 32'(IDLE));
    rd_reg(4'h0, 8'h00);
    rd_reg(4'h3, 8'h00);
    rd_reg(4'h6, 8'h00);

    // levels held high across reset release
    reset     = 1'b0;
    txn_start = 1'b1;
    rx_data   = 8'h33;
    rx_valid  = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("hl_st", 32'(dut.state_q), 32'(IDLE));
    chk("hl_strb", 32'(wr_strobe), 32'(0));
    tick();
    chk("hl_strb2", 32'(wr_strobe), 32'(0));
    chk("hl_ptr", 32'(dut.ptr_q), 32'(0));
    txn_start = 1'b0;
    rx_valid  = 1'b0;
    rd_reg(4'h0, 8'h00);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, register-index width, giving 2**ADDR_W registers.
REQ-002 The block SHALL have parameter RESET_VAL, default 8'h00, the reset value of every register.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port txn_start, input, 1, a level whose rising edge marks I2C START or repeated START addressed to this slave.
REQ-006 The block SHALL have port rx_data, input, 8, the received data byte, stable while rx_valid is high.
REQ-007 The block SHALL have port rx_valid, input, 1, a level whose rising edge marks one new received data byte; the address byte is never presented.
REQ-008 The block SHALL have port tx_req, input, 1, a level whose rising edge marks that the byte on tx_data has been consumed for transmission.
REQ-009 The block SHALL have port tx_data, output, 8, the byte offered to the I2C slave for the next read.
REQ-010 The block SHALL have ports host_addr (input, ADDR_W), host_wdata (input, 8) and host_we (input, 1), forming the local-side synchronous write port.
REQ-011 The block SHALL have port host_rdata, output, 8, equal to reg[host_addr] registered one cycle.
REQ-012 The block SHALL have ports wr_strobe (output, 1) and wr_addr (output, ADDR_W), a one-cycle pulse with the index of a register written from I2C.
REQ-013 The block SHALL have port host_collision, output, 1, a one-cycle pulse when a host write is dropped.

Function
REQ-014 All inputs SHALL be treated as synchronous to clk, with no synchronisers.
REQ-015 Edges SHALL be detected as input=1 with the previous-cycle sample=0; previous-sample flops reset to 1, so a level already high at reset release causes no edge.
REQ-016 The FSM SHALL have the states IDLE, PTR (next written byte is the register pointer) and DATA (written bytes go to the registers).
REQ-017 A txn_start edge in any state SHALL move the FSM to PTR, leave the pointer unchanged, and take priority over an rx/tx edge in the same cycle, which is ignored.
REQ-018 An rx edge in PTR SHALL load ptr <= rx_data[ADDR_W-1:0], ignore the upper bits, and move the FSM to DATA.
REQ-019 An rx edge in DATA SHALL write reg[ptr] <= rx_data and increment ptr modulo 2**ADDR_W (the top index wraps to 0).
REQ-020 An rx edge in IDLE SHALL be ignored.
REQ-021 Registers and ptr SHALL update on the same clock edge at which the rx edge is detected.
REQ-022 wr_strobe/wr_addr SHALL assert on the following cycle, carrying the pre-increment index.
REQ-023 tx_data SHALL equal reg[ptr] registered each cycle, so it reflects a pointer or register update one cycle later.
REQ-024 A tx_req edge in any state other than IDLE SHALL increment ptr with wrap and SHALL NOT change the FSM state, so a read after a repeated START begins at the pointer last written.
REQ-025 rx and tx edges in the same cycle SHALL apply the rx rule only, with a single pointer increment.
REQ-026 A host write in a cycle with no I2C write to the same index SHALL update the register at that edge.
REQ-027 When the host and I2C write the same index in the same cycle, the I2C write SHALL win and host_collision SHALL pulse.
REQ-028 Host writes SHALL NOT generate wr_strobe and SHALL NOT move ptr.

Reset
REQ-029 While reset=0, the block SHALL force state=IDLE, ptr=0, every register to RESET_VAL, tx_data=RESET_VAL, host_rdata=RESET_VAL, wr_strobe=0, wr_addr=0 and host_collision=0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction immediately with no partial write; the first byte after release requires a new txn_start edge.

Structure
REQ-031 The FSM state encodings (IDLE/PTR/DATA) and ADDR_W/RESET_VAL defaults SHALL live in the shared I2C constants header used by the slave.
REQ-032 The three edge detectors SHALL be instances of one sub-module, edge_rise (1-bit, reset-to-1 previous sample).
REQ-033 The register array SHALL be flops, not inferred RAM, to allow the single-cycle reset.

Verification
REQ-034 The bench SHALL cover an I2C write: txn_start, rx bytes 8'h03, 8'hA5, 8'h5A -> reg3=A5, reg4=5A, wr_strobe pulses with wr_addr 3 then 4, ptr=5.
REQ-035 The bench SHALL cover a combined read: preload reg7=8'h11 and reg8=8'h22, then txn_start, rx 8'h07, txn_start, then two tx_req edges -> tx_data 11 then 22, ptr=9.
REQ-036 The bench SHALL cover wrap-around: pointer 8'hFF (loads 4'hF), rx 8'hC1, 8'hC2 -> reg15=C1, reg0=C2.
REQ-037 The bench SHALL cover a collision: host_we to index 2 with 8'h99 in the same cycle as an I2C write of 8'h44 to reg2 -> reg2=44, host_collision one-cycle pulse.
REQ-038 The bench SHALL cover reset mid-transaction: reset low after the pointer byte, then release, then rx 8'hEE with no txn_start -> no register changes, ptr=0, state IDLE.
REQ-039 The bench SHALL cover a level held high across reset release: rx_valid=1 held across release -> no write, no wr_strobe.
